joybus_bit_decoder: RTL and testbench
=====================================

// Module: joybus_bit_decoder
// PURPOSE
//   Oversampling decoder for the single-wire, open-drain Joybus line on the fake_n64 controller side.
//   Synchronises the asynchronous line and measures each bit's low and high phase with saturating counters.
//   Decides each bit from the low/high ratio, assembles bits MSB-first into bytes, and detects the stop
//   bit / end of frame by idle timeout.
//   Sits between the pad and the command parser. Fully synchronous to clk; no derived clocks.
// PARAMETERS
//   CNT_W        6   phase-counter width; counters saturate at 2^CNT_W-1
//   SYNC_STAGES  2   input synchroniser depth (>=2)
//   IDLE_CYCLES  32  consecutive high cycles that mark idle/end of frame; must be < 2^CNT_W
// PORTS
//   clk         in   1  oversampling clock
//   reset       in   1  reset, asynchronous, active-high
//   data_in     in   1  raw Joybus line, asynchronous to clk, idles high
//   enable      in   1  0 = decoder held in RESYNC, no output pulses
//   bit_valid   out  1  1-cycle pulse: bit_value holds a decoded data bit
//   bit_value   out  1  decoded bit; held until the next bit_valid
//   byte_valid  out  1  1-cycle pulse: byte_data complete
//   byte_data   out  8  assembled byte, MSB first; held until the next byte_valid
//   frame_end   out  1  1-cycle pulse: stop bit seen, then idle timeout
//   frame_err   out  1  1-cycle pulse: partial byte at frame end, or low phase saturated
//   line_idle   out  1  level: decoder in IDLE, line quiet
// BEHAVIOUR
//   Reset values: all outputs 0; synchroniser flops 1; counters 0; bit_cnt 0; state RESYNC.
//   data_s = data_in delayed SYNC_STAGES clk cycles. fall = data_q & ~data_s; rise = ~data_q & data_s.
//     data_q is data_s delayed by one cycle.
//   Outputs are registered: each is asserted the cycle after its decision cycle.
//   States:
//   - RESYNC
//     - high_cnt increments while data_s=1 and clears on data_s=0.
//     - high_cnt==IDLE_CYCLES -> IDLE.
//   - IDLE
//     - line_idle=1.
//     - fall -> LOW with low_cnt=1.
//   - LOW
//     - data_s=0 -> low_cnt saturating increment.
//     - low_cnt at 2^CNT_W-1 -> frame_err pulse, bit_cnt=0, RESYNC.
//     - rise -> low_lat=low_cnt, high_cnt=1, HIGH.
//   - HIGH
//     - data_s=1 -> high_cnt increment.
//     - fall -> emit bit, low_cnt=1, LOW.
//     - high_cnt==IDLE_CYCLES without fall -> the preceding low was the stop bit, not data.
//       Then: frame_end pulse; frame_err pulse also if bit_cnt!=0; bit_cnt=0; IDLE.
//     - A fall takes priority over the timeout in the same cycle.
//   Bit decision: bit = (low_lat > high_cnt) ? 0 : 1. A tie decodes as 1.
//     high_cnt includes the fall cycle's count.
//   Byte assembly: shift_reg = {shift_reg[6:0], bit}; bit_cnt increments mod 8.
//     The 8th bit asserts byte_valid in the same cycle as its bit_valid, with byte_data = full shift value.
//   enable=0: state forced to RESYNC next cycle, bit_cnt=0, no pulses. Deasserting enable mid-frame is a
//     silent abort.
//   reset mid-operation: outputs cleared immediately; the partial byte is discarded; a full RESYNC is
//     required before the next frame.
//   Counters never wrap. Widths are exact; no combinational path from data_in to any output.
// TESTING  (CNT_W=6, SYNC_STAGES=2, IDLE_CYCLES=32; "0" = 12 low/4 high, "1" = 4 low/12 high, stop = 4 low)
//   1 Reset, enable=1, line high 40 cycles -> line_idle rises 1 cycle after 32nd sampled high; no pulses.
//   2 Byte 0x80 + stop + high -> 8 bit_valid (1,0,0,0,0,0,0,0), byte_valid with 8'h80, frame_end, frame_err=0.
//   3 Bytes 0xA5,0x3C back-to-back + stop -> byte_valid x2 with 8'hA5 then 8'h3C; one frame_end.
//   4 Tie bit 8 low/8 high, then bits 0,1 + stop -> bit_value 1,0,1; frame_end plus frame_err (bit_cnt=3).
//   5 Line held low 70 cycles -> frame_err when low_cnt hits 63; line_idle=0 until 32 high cycles pass.
//   6 Reset asserted after 5 bits of 0xFF -> outputs 0 at once; after RESYNC, 0x55 decodes with byte_data 8'h55.
//     Repeat with enable=0 in place of reset -> no pulses, same recovery.

Source files
------------

// File: rtl/joybus_bit_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : joybus_bit_decoder                                              |
// | Brief    : Oversampling Joybus bit/byte decoder with idle-timeout framing. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module joybus_bit_decoder #(
    parameter int CNT_W       = 6,
    parameter int SYNC_STAGES = 2,
    parameter int IDLE_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_in,
    input  logic       enable,
    output logic       bit_valid,
    output logic       bit_value,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_end,
    output logic       frame_err,
    output logic       line_idle
);

    localparam logic [1:0]       c_st_resync = 2'd0;
    localparam logic [1:0]       c_st_idle   = 2'd1;
    localparam logic [1:0]       c_st_low    = 2'd2;
    localparam logic [1:0]       c_st_high   = 2'd3;
    localparam logic [CNT_W-1:0] c_cnt_max   = '1;
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_idle_cnt  = CNT_W'(IDLE_CYCLES);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_data_q;
    logic [1:0]             r_state;
    logic [CNT_W-1:0]       r_low_cnt;
    logic [CNT_W-1:0]       r_high_cnt;
    logic [CNT_W-1:0]       r_low_lat;
    logic [2:0]             r_bit_cnt;
    logic [6:0]             r_shift;

    logic                   w_data_s;
    logic                   w_fall;
    logic                   w_rise;
    logic                   w_bit;
    logic [CNT_W:0]         w_high_eff;
    logic [1:0]             w_state_nx;
    logic [CNT_W-1:0]       w_low_nx;
    logic [CNT_W-1:0]       w_high_nx;
    logic [CNT_W-1:0]       w_lat_nx;
    logic [2:0]             w_bit_cnt_nx;
    logic [6:0]             w_shift_nx;
    logic                   w_bit_valid_nx;
    logic                   w_bit_value_nx;
    logic                   w_byte_valid_nx;
    logic [7:0]             w_byte_data_nx;
    logic                   w_frame_end_nx;
    logic                   w_frame_err_nx;

    assign w_data_s   = r_sync[SYNC_STAGES-1];
    assign w_fall     = r_data_q & ~w_data_s;
    assign w_rise     = ~r_data_q & w_data_s;
    // The falling cycle closes the high phase, so it is counted as one more high sample.
    assign w_high_eff = {1'b0, r_high_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign w_bit      = ({1'b0, r_low_lat} > w_high_eff) ? 1'b0 : 1'b1;

    always_comb begin
        w_state_nx      = r_state;
        w_low_nx        = r_low_cnt;
        w_high_nx       = r_high_cnt;
        w_lat_nx        = r_low_lat;
        w_bit_cnt_nx    = r_bit_cnt;
        w_shift_nx      = r_shift;
        w_bit_valid_nx  = 1'b0;
        w_bit_value_nx  = bit_value;
        w_byte_valid_nx = 1'b0;
        w_byte_data_nx  = byte_data;
        w_frame_end_nx  = 1'b0;
        w_frame_err_nx  = 1'b0;

        if (!enable) begin
            w_state_nx   = c_st_resync;
            w_high_nx    = '0;
            w_bit_cnt_nx = '0;
        end else begin
            case (r_state)
                c_st_resync: begin
                    if (!w_data_s)
                        w_high_nx = '0;
                    else if (r_high_cnt == c_idle_cnt)
                        w_state_nx = c_st_idle;
                    else if (r_high_cnt != c_cnt_max)
                        w_high_nx = r_high_cnt + c_cnt_one;
                end
                c_st_idle: begin
                    if (w_fall) begin
                        w_low_nx   = c_cnt_one;
                        w_state_nx = c_st_low;
                    end
                end
                c_st_low: begin
                    if (r_low_cnt == c_cnt_max) begin
                        w_frame_err_nx = 1'b1;
                        w_bit_cnt_nx   = '0;
                        w_high_nx      = '0;
                        w_state_nx     = c_st_resync;
                    end else if (w_rise) begin
                        w_lat_nx   = r_low_cnt;
                        w_high_nx  = c_cnt_one;
                        w_state_nx = c_st_high;
                    end else if (!w_data_s) begin
                        w_low_nx = r_low_cnt + c_cnt_one;
                    end
                end
                default: begin
                    if (w_fall) begin
                        w_bit_valid_nx = 1'b1;
                        w_bit_value_nx = w_bit;
                        w_shift_nx     = {r_shift[5:0], w_bit};
                        w_bit_cnt_nx   = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_byte_valid_nx = 1'b1;
                            w_byte_data_nx  = {r_shift, w_bit};
                        end
                        w_low_nx   = c_cnt_one;
                        w_state_nx = c_st_low;
                    end else if (r_high_cnt == c_idle_cnt) begin
                        // No further fall: the last low phase was the stop bit.
                        w_frame_end_nx = 1'b1;
                        w_frame_err_nx = (r_bit_cnt != 3'd0);
                        w_bit_cnt_nx   = '0;
                        w_state_nx     = c_st_idle;
                    end else if (w_data_s && (r_high_cnt != c_cnt_max)) begin
                        w_high_nx = r_high_cnt + c_cnt_one;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync     <= '1;
            r_data_q   <= 1'b1;
            r_state    <= c_st_resync;
            r_low_cnt  <= '0;
            r_high_cnt <= '0;
            r_low_lat  <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            bit_valid  <= 1'b0;
            bit_value  <= 1'b0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_end  <= 1'b0;
            frame_err  <= 1'b0;
            line_idle  <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], data_in};
            r_data_q   <= w_data_s;
            r_state    <= w_state_nx;
            r_low_cnt  <= w_low_nx;
            r_high_cnt <= w_high_nx;
            r_low_lat  <= w_lat_nx;
            r_bit_cnt  <= w_bit_cnt_nx;
            r_shift    <= w_shift_nx;
            bit_valid  <= w_bit_valid_nx;
            bit_value  <= w_bit_value_nx;
            byte_valid <= w_byte_valid_nx;
            byte_data  <= w_byte_data_nx;
            frame_end  <= w_frame_end_nx;
            frame_err  <= w_frame_err_nx;
            line_idle  <= (w_state_nx == c_st_idle);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_joybus_bit_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : tb_joybus_bit_decoder                                           |
// | Brief    : Directed self-checking bench for joybus_bit_decoder.            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_joybus_bit_decoder;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       data_in = 1'b1;
    logic       enable  = 1'b1;
    logic       bit_valid;
    logic       bit_value;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_end;
    logic       frame_err;
    logic       line_idle;

    joybus_bit_decoder #(
        .CNT_W       (6),
        .SYNC_STAGES (2),
        .IDLE_CYCLES (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .enable     (enable),
        .bit_valid  (bit_valid),
        .bit_value  (bit_value),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_end  (frame_end),
        .frame_err  (frame_err),
        .line_idle  (line_idle)
    );

    always #5 clk = ~clk;

    // Pulse recorder: monotonic counts, bit history and byte history.
    int          n_bits  = 0;
    int          n_bytes = 0;
    int          n_fe    = 0;
    int          n_err   = 0;
    logic [31:0] bits_w  = '0;
    logic [7:0]  bytes_q[$];

    always @(negedge clk) begin
        if (bit_valid) begin
            n_bits++;
            bits_w = {bits_w[30:0], bit_value};
        end
        if (byte_valid) begin
            n_bytes++;
            bytes_q.push_back(byte_data);
        end
        if (frame_end) n_fe++;
        if (frame_err) n_err++;
    end

    int total  = 0;
    int passed = 0;
    int failed = 0;
    int b_bits, b_bytes, b_fe, b_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        b_bits  = n_bits;
        b_bytes = n_bytes;
        b_fe    = n_fe;
        b_err   = n_err;
    endtask

    task automatic line(input logic v, input int n);
        repeat (n) begin
            @(negedge clk);
            data_in = v;
        end
    endtask

    task automatic send_bit(input logic b);
        if (b) begin
            line(1'b0, 4);
            line(1'b1, 12);
        end else begin
            line(1'b0, 12);
            line(1'b1, 4);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic stop_and_idle();
        line(1'b0, 4);
        line(1'b1, 45);
    endtask

    function automatic logic [31:0] outs();
        return {19'd0, bit_valid, bit_value, byte_valid, byte_data, frame_end, frame_err, line_idle};
    endfunction

    initial begin
        // 1: reset state and idle detection timing
        repeat (3) @(negedge clk);
        check("reset_outputs", outs(), 32'd0);
        reset = 1'b0;
        repeat (32) @(negedge clk);
        check("idle_after_32", {31'd0, line_idle}, 32'd0);
        @(negedge clk);
        check("idle_after_33", {31'd0, line_idle}, 32'd1);
        repeat (6) @(negedge clk);
        check("t1_no_pulses", n_bits + n_bytes + n_fe + n_err, 32'd0);

        // 2: single byte 0x80
        mark();
        send_byte(8'h80);
        stop_and_idle();
        check("t2_bit_count", n_bits - b_bits, 32'd8);
        check("t2_bits", {24'd0, bits_w[7:0]}, 32'h80);
        check("t2_byte_count", n_bytes - b_bytes, 32'd1);
        check("t2_byte", {24'd0, bytes_q[b_bytes]}, 32'h80);
        check("t2_frame_end", n_fe - b_fe, 32'd1);
        check("t2_frame_err", n_err - b_err, 32'd0);
        check("t2_idle", {31'd0, line_idle}, 32'd1);

        // 3: two back-to-back bytes
        mark();
        send_byte(8'hA5);
        send_byte(8'h3C);
        stop_and_idle();
        check("t3_byte_count", n_bytes - b_bytes, 32'd2);
        check("t3_byte0", {24'd0, bytes_q[b_bytes]}, 32'hA5);
        check("t3_byte1", {24'd0, bytes_q[b_bytes+1]}, 32'h3C);
        check("t3_bits", {16'd0, bits_w[15:0]}, 32'hA53C);
        check("t3_frame_end", n_fe - b_fe, 32'd1);
        check("t3_frame_err", n_err - b_err, 32'd0);

        // 4: tie bit decodes as 1, partial byte at frame end
        mark();
        line(1'b0, 8);
        line(1'b1, 8);
        send_bit(1'b0);
        send_bit(1'b1);
        stop_and_idle();
        check("t4_bit_count", n_bits - b_bits, 32'd3);
        check("t4_bits", {29'd0, bits_w[2:0]}, 32'd5);
        check("t4_byte_count", n_bytes - b_bytes, 32'd0);
        check("t4_frame_end", n_fe - b_fe, 32'd1);
        check("t4_frame_err", n_err - b_err, 32'd1);

        // 5: low phase saturation
        mark();
        line(1'b0, 10);
        check("t5_idle_low", {31'd0, line_idle}, 32'd0);
        line(1'b0, 60);
        check("t5_sat_err", n_err - b_err, 32'd1);
        check("t5_no_fe", n_fe - b_fe, 32'd0);
        line(1'b1, 20);
        check("t5_idle_20hi", {31'd0, line_idle}, 32'd0);
        line(1'b1, 25);
        check("t5_idle_45hi", {31'd0, line_idle}, 32'd1);
        check("t5_no_bits", n_bits - b_bits, 32'd0);

        // 6a: reset mid-byte, then recovery
        mark();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        check("t6_partial_bits", n_bits - b_bits, 32'd4);
        check("t6_held_byte", {24'd0, byte_data}, 32'h3C);
        check("t6_held_bit", {31'd0, bit_value}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("t6_reset_outputs", outs(), 32'd0);
        data_in = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        line(1'b1, 40);
        check("t6_resync_idle", {31'd0, line_idle}, 32'd1);
        mark();
        send_byte(8'h55);
        stop_and_idle();
        check("t6_byte_count", n_bytes - b_bytes, 32'd1);
        check("t6_byte", {24'd0, bytes_q[b_bytes]}, 32'h55);
        check("t6_frame_end", n_fe - b_fe, 32'd1);
        check("t6_frame_err", n_err - b_err, 32'd0);

        // 6b: enable dropped mid-byte is a silent abort
        mark();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        check("t6e_partial_bits", n_bits - b_bits, 32'd4);
        @(negedge clk);
        enable = 1'b0;
        mark();
        line(1'b1, 10);
        check("t6e_idle_off", {31'd0, line_idle}, 32'd0);
        line(1'b0, 12);
        line(1'b1, 12);
        line(1'b0, 4);
        line(1'b1, 40);
        check("t6e_no_pulses", n_bits + n_bytes + n_fe + n_err - b_bits - b_bytes - b_fe - b_err, 32'd0);
        check("t6e_idle_still_off", {31'd0, line_idle}, 32'd0);
        enable = 1'b1;
        line(1'b1, 40);
        check("t6e_resync_idle", {31'd0, line_idle}, 32'd1);
        mark();
        send_byte(8'h55);
        stop_and_idle();
        check("t6e_byte_count", n_bytes - b_bytes, 32'd1);
        check("t6e_byte", {24'd0, bytes_q[b_bytes]}, 32'h55);
        check("t6e_frame_end", n_fe - b_fe, 32'd1);
        check("t6e_frame_err", n_err - b_err, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
